gmii_tx_framer: RTL and testbench
=================================

Name: gmii_tx_framer

Overview:
- Transmit-side MAC framer; the TX counterpart of the RX error/invalidate path.
- Takes a byte stream from the TX packet source and drives the GMII TX interface.
- Inserts the preamble and SFD, optionally pads short frames, and appends the FCS.
- Enforces the inter-packet gap (IPG) and invalidates in-flight frames on source underrun or error by asserting GMII error.

Parameters:
- IPG_BYTES, 12, idle cycles between frames; minimum 12.
- PREAMBLE_BYTES, 7, number of 0x55 bytes before the SFD.
- MIN_PAYLOAD_BYTES, 60, minimum payload length before the FCS when padding is enabled.

Ports:
- clk  input  1  GMII TX clock, 125 MHz.
- rst  input  1  synchronous, active-high reset.
- s_data_i  input  8  payload byte.
- s_valid_i  input  1  payload byte valid.
- s_last_i  input  1  last payload byte of the frame.
- s_error_i  input  1  source marks the current byte as bad; abort the frame.
- s_ready_o  output  1  framer accepts a byte this cycle.
- gmii_tx_if_o  gmii_if.master  -  valid/data[7:0]/error to the PHY; all fields registered.
- tx_abort_o  output  1  one-cycle pulse when a frame is invalidated.
- tx_done_o  output  1  one-cycle pulse when the last FCS byte is sent.

Behaviour:
- Reset: state IDLE; s_ready_o=0; gmii valid=0, data=0x00, error=0; tx_abort_o=0; tx_done_o=0; all counters 0. Reset mid-frame takes effect on the next edge (valid=0); no error is emitted.
- Handshake: a byte transfers when s_valid_i && s_ready_o. s_ready_o is combinational from state and is high only in PAYLOAD and DRAIN.
- IDLE:
  - On s_valid_i, go to PREAMBLE; the byte is not consumed.
  - The first 0x55 appears on GMII the next cycle.
- PREAMBLE: drive PREAMBLE_BYTES cycles of 0x55, then go to SFD.
- SFD: drive 0xD5, then go to PAYLOAD.
- PAYLOAD:
  - Byte accepted at cycle N appears on GMII at N+1.
  - A saturating byte counter (7-bit, saturates at MIN_PAYLOAD_BYTES) and the CRC update on each accepted byte.
  - s_valid_i low is an underrun.
  - Accepted byte with s_error_i=1 is an error.
  - Accepted byte with s_last_i: go to PAD if padding is enabled and count < MIN_PAYLOAD_BYTES-1; otherwise go to FCS.
- Underrun or error:
  - Next cycle, GMII valid=1, error=1, data=0x00, and tx_abort_o=1.
  - If the offending byte carried s_last_i, or the cause was an underrun on a byte already marked last, go to IPG. Otherwise go to DRAIN.
- DRAIN: GMII valid=0; s_ready_o=1; discard bytes until one with s_last_i is accepted, then go to IPG. If s_error_i and s_last_i arrive together, s_last_i still ends DRAIN.
- PAD: drive 0x00 and feed it into the CRC until the count reaches MIN_PAYLOAD_BYTES, then go to FCS.
- FCS:
  - CRC-32, reflected, poly 0xEDB88320, init 0xFFFFFFFF.
  - Transmitted value is ~crc, bits [7:0] first, 4 cycles.
  - tx_done_o pulses with the 4th byte; then go to IPG.
- IPG: GMII valid=0 for IPG_BYTES cycles, counted from the cycle after the last valid byte (FCS or error byte). s_valid_i is ignored here. Then go to IDLE.
- Counters: the preamble counter is 3 bits, the IPG counter is 4 bits, and the FCS index is 2 bits. None wrap mid-state.
- Frames longer than 1518 bytes are not truncated; enforcing that limit is the source's job.

Optional Feature:
- Macro: GMII_TX_PAD_EN.
- Defined: frames with fewer than MIN_PAYLOAD_BYTES payload bytes are zero-padded, and the CRC covers the pad.
- Undefined: the PAD state is absent, and FCS follows the last payload byte directly regardless of length.

Decomposition:
- Package gmii_tx_pkg holds:
  - the tx_state_t enum: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, DRAIN, FCS, IPG;
  - localparams PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF.
- Sub-module crc32_d8: combinational next-CRC for one byte (crc_i, data_i -> crc_o). The framer holds the CRC register.

Test Plan:
- 60-byte frame 0x00..0x3B, s_valid_i held high → 7×0x55, 0xD5, the 60 bytes, 4 FCS bytes (72 valid cycles); tx_done_o on the last; next frame's preamble ≥12 idle cycles later.
- GMII_TX_PAD_EN undefined, payload ASCII "123456789" → FCS bytes 0x26, 0x39, 0xF4, 0xCB.
- GMII_TX_PAD_EN defined, 10-byte payload → 50×0x00 pad, then FCS computed over 60 bytes (checked against the model); 72 valid cycles total.
- 100-byte frame with s_valid_i dropped at byte 20 → one GMII cycle with valid=1, error=1, and tx_abort_o pulse; remaining 80 bytes drained with valid=0; IPG follows.
- s_error_i on byte 5 of a 30-byte frame → error byte at the cycle after byte 5 is accepted; DRAIN until s_last_i; no FCS emitted and no tx_done_o.
- rst asserted at payload byte 15 → next cycle valid=0, error=0, s_ready_o=0; a new frame afterwards starts cleanly with a fresh CRC.

Source files
------------

// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit framer.
package gmii_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      SFD,
      PAYLOAD,
      PAD,
      DRAIN,
      FCS,
      IPG
   } tx_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

   localparam int unsigned PRE_CNT_W  = 3;
   localparam int unsigned IPG_CNT_W  = 4;
   localparam int unsigned BYTE_CNT_W = 7;
   localparam int unsigned FCS_IDX_W  = 2;

endpackage

// File: rtl/gmii_if.sv
// GMII transmit bundle: byte-wide data with valid and error qualifiers.
interface gmii_if;
   logic       valid;
   logic [7:0] data;
   logic       error;

   modport master (output valid, output data, output error);
   modport slave  (input valid, input data, input error);
endinterface

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module crc32_d8
   import gmii_tx_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   always_comb begin
      crc_o = crc_i ^ {24'h000000, data_i};
      for (int i = 0; i < 8; i++) begin
         crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY) : (crc_o >> 1);
      end
   end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII TX framer: preamble/SFD insertion, optional short-frame padding, FCS append,
// IPG enforcement and frame invalidation. Padding is enabled by defining GMII_TX_PAD_EN.
module gmii_tx_framer
   import gmii_tx_pkg::*;
#(
   parameter int unsigned IPG_BYTES         = 12,
   parameter int unsigned PREAMBLE_BYTES    = 7,
   parameter int unsigned MIN_PAYLOAD_BYTES = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data_i,
   input  logic       s_valid_i,
   input  logic       s_last_i,
   input  logic       s_error_i,
   output logic       s_ready_o,
   gmii_if.master     gmii_tx_if_o,
   output logic       tx_abort_o,
   output logic       tx_done_o
);

`ifdef GMII_TX_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   tx_state_t               state_q, state_d;
   logic [PRE_CNT_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic [IPG_CNT_W-1:0]    ipg_cnt_q, ipg_cnt_d;
   logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
   logic [FCS_IDX_W-1:0]    fcs_idx_q, fcs_idx_d;
   logic [31:0]             crc_q, crc_d, crc_next, fcs_word;
   logic [7:0]              crc_byte;
   logic                    valid_q, valid_d;
   logic [7:0]              data_q, data_d;
   logic                    error_q, error_d;
   logic                    abort_q, abort_d;
   logic                    done_q, done_d;

   assign s_ready_o = (state_q == PAYLOAD) || (state_q == DRAIN);

   // Pad bytes are zeros, so the CRC input is only the source byte while in PAYLOAD.
   assign crc_byte = (state_q == PAYLOAD) ? s_data_i : 8'h00;
   assign fcs_word = ~crc_q;
   assign byte_cnt_inc = (byte_cnt_q < 7'(MIN_PAYLOAD_BYTES)) ? byte_cnt_q + 7'd1 : byte_cnt_q;

   crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i (crc_byte),
      .crc_o  (crc_next)
   );

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      ipg_cnt_d  = ipg_cnt_q;
      byte_cnt_d = byte_cnt_q;
      fcs_idx_d  = fcs_idx_q;
      crc_d      = crc_q;
      valid_d    = 1'b0;
      data_d     = 8'h00;
      error_d    = 1'b0;
      abort_d    = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            crc_d      = CRC32_INIT;
            pre_cnt_d  = '0;
            ipg_cnt_d  = '0;
            byte_cnt_d = '0;
            fcs_idx_d  = '0;
            if (s_valid_i) begin
               valid_d   = 1'b1;
               data_d    = PREAMBLE_BYTE;
               pre_cnt_d = 3'd1;
               state_d   = (PREAMBLE_BYTES > 1) ? PREAMBLE : SFD;
            end
         end

         PREAMBLE: begin
            valid_d   = 1'b1;
            data_d    = PREAMBLE_BYTE;
            pre_cnt_d = pre_cnt_q + 3'd1;
            if (pre_cnt_q == 3'(PREAMBLE_BYTES - 1)) begin
               state_d = SFD;
            end
         end

         SFD: begin
            valid_d = 1'b1;
            data_d  = SFD_BYTE;
            state_d = PAYLOAD;
         end

         PAYLOAD: begin
            valid_d = 1'b1;
            if (!s_valid_i || s_error_i) begin
               // Invalidate the frame on the wire; finish it off in DRAIN unless already at its end.
               error_d = 1'b1;
               abort_d = 1'b1;
               state_d = s_last_i ? IPG : DRAIN;
            end else begin
               data_d     = s_data_i;
               crc_d      = crc_next;
               byte_cnt_d = byte_cnt_inc;
               if (s_last_i) begin
                  if (PAD_EN && (byte_cnt_q < 7'(MIN_PAYLOAD_BYTES - 1))) begin
                     state_d = PAD;
                  end else begin
                     state_d = FCS;
                  end
               end
            end
         end

`ifdef GMII_TX_PAD_EN
         PAD: begin
            valid_d    = 1'b1;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc;
            if (byte_cnt_q == 7'(MIN_PAYLOAD_BYTES - 1)) begin
               state_d = FCS;
            end
         end
`endif

         DRAIN: begin
            if (s_valid_i && s_last_i) begin
               state_d = IPG;
            end
         end

         FCS: begin
            valid_d   = 1'b1;
            data_d    = fcs_word[{fcs_idx_q, 3'b000} +: 8];
            fcs_idx_d = fcs_idx_q + 2'd1;
            if (fcs_idx_q == 2'd3) begin
               done_d  = 1'b1;
               state_d = IPG;
            end
         end

         IPG: begin
            ipg_cnt_d = ipg_cnt_q + 4'd1;
            if (ipg_cnt_q == 4'(IPG_BYTES - 1)) begin
               ipg_cnt_d = '0;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pre_cnt_q  <= '0;
         ipg_cnt_q  <= '0;
         byte_cnt_q <= '0;
         fcs_idx_q  <= '0;
         crc_q      <= CRC32_INIT;
         valid_q    <= 1'b0;
         data_q     <= 8'h00;
         error_q    <= 1'b0;
         abort_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         ipg_cnt_q  <= ipg_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         fcs_idx_q  <= fcs_idx_d;
         crc_q      <= crc_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         error_q    <= error_d;
         abort_q    <= abort_d;
         done_q     <= done_d;
      end
   end

   assign gmii_tx_if_o.valid = valid_q;
   assign gmii_tx_if_o.data  = data_q;
   assign gmii_tx_if_o.error = error_q;
   assign tx_abort_o         = abort_q;
   assign tx_done_o          = done_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: frame table plus hand-written reset and known-CRC sequences.
module tb_gmii_tx_framer;

   localparam int PRE  = 7;
   localparam int IPG  = 12;
   localparam int MINP = 60;
   localparam int NONE = 1000;
   localparam int NVEC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data_i = 8'h00;
   logic       s_valid_i = 1'b0;
   logic       s_last_i = 1'b0;
   logic       s_error_i = 1'b0;
   logic       s_ready_o;
   logic       tx_abort_o;
   logic       tx_done_o;

   gmii_if gmii ();

   gmii_tx_framer #(
      .IPG_BYTES         (IPG),
      .PREAMBLE_BYTES    (PRE),
      .MIN_PAYLOAD_BYTES (MINP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_data_i     (s_data_i),
      .s_valid_i    (s_valid_i),
      .s_last_i     (s_last_i),
      .s_error_i    (s_error_i),
      .s_ready_o    (s_ready_o),
      .gmii_tx_if_o (gmii),
      .tx_abort_o   (tx_abort_o),
      .tx_done_o    (tx_done_o)
   );

   always #4 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       err;
      logic       done;
   } exp_t;

   typedef struct {
      int len;
      int under_at;
      int err_at;
      int exp_valid;
      int exp_done;
      int exp_abort;
   } vec_t;

   exp_t       exp_q[$];
   vec_t       vecs[NVEC];
   logic [7:0] pl[0:255];
   int         checks = 0;
   int         failures = 0;
   int         n_valid = 0;
   int         n_done = 0;
   int         n_abort = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int b = 0; b < 8; b++) begin
         fb = r[0] ^ d[b];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   task automatic push(input logic [7:0] d, input logic e, input logic dn);
      exp_t x;
      x.data = d;
      x.err  = e;
      x.done = dn;
      exp_q.push_back(x);
   endtask

   task automatic push_hdr();
      for (int k = 0; k < PRE; k++) push(8'h55, 1'b0, 1'b0);
      push(8'hD5, 1'b0, 1'b0);
   endtask

   // Expected wire image of a frame from pl[]: good bytes, then either the error byte or pad+FCS.
   task automatic push_frame(input int len, input int under_at, input int err_at);
      int          stop;
      int          n;
      logic [31:0] c;
      stop = len;
      if (under_at < stop) stop = under_at;
      if (err_at < stop) stop = err_at;
      push_hdr();
      for (int k = 0; k < stop; k++) push(pl[k], 1'b0, 1'b0);
      if (stop < len) begin
         push(8'h00, 1'b1, 1'b0);
      end else begin
         c = 32'hFFFFFFFF;
         for (int k = 0; k < len; k++) c = crc_model(c, pl[k]);
         n = len;
`ifdef GMII_TX_PAD_EN
         while (n < MINP) begin
            push(8'h00, 1'b0, 1'b0);
            c = crc_model(c, 8'h00);
            n++;
         end
`endif
         c = ~c;
         push(c[7:0], 1'b0, 1'b0);
         push(c[15:8], 1'b0, 1'b0);
         push(c[23:16], 1'b0, 1'b0);
         push(c[31:24], 1'b0, 1'b1);
      end
   endtask

   // Source model: inputs change on the falling edge; one underrun cycle may be injected.
   task automatic drive_frame(input int len, input int under_at, input int err_at, input int stop_at);
      int i;
      int guard;
      bit dropped;
      bit acc;
      i = 0;
      guard = 0;
      dropped = 1'b0;
      @(negedge clk);
      while (i < stop_at && guard < 2000) begin
         if (s_ready_o && i == under_at && !dropped) begin
            s_valid_i = 1'b0;
            dropped   = 1'b1;
         end else begin
            s_valid_i = 1'b1;
            s_data_i  = pl[i];
            s_last_i  = (i == len - 1);
            s_error_i = (i == err_at);
         end
         acc = s_valid_i && s_ready_o;
         @(negedge clk);
         if (acc) i++;
         guard++;
      end
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_error_i = 1'b0;
      chk("drive_accepted", 32'(i), 32'(stop_at));
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 400) begin
         @(negedge clk);
         g++;
      end
      repeat (IPG + 2) @(negedge clk);
      chk("frame_complete_queue", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int b_valid;
      int b_done;
      int b_abort;

      vecs[0] = '{len: 60,  under_at: NONE, err_at: NONE, exp_valid: 72, exp_done: 1, exp_abort: 0};
`ifdef GMII_TX_PAD_EN
      vecs[1] = '{len: 10,  under_at: NONE, err_at: NONE, exp_valid: 72, exp_done: 1, exp_abort: 0};
      vecs[6] = '{len: 1,   under_at: NONE, err_at: NONE, exp_valid: 72, exp_done: 1, exp_abort: 0};
`else
      vecs[1] = '{len: 10,  under_at: NONE, err_at: NONE, exp_valid: 22, exp_done: 1, exp_abort: 0};
      vecs[6] = '{len: 1,   under_at: NONE, err_at: NONE, exp_valid: 13, exp_done: 1, exp_abort: 0};
`endif
      vecs[2] = '{len: 100, under_at: 20,   err_at: NONE, exp_valid: 29, exp_done: 0, exp_abort: 1};
      vecs[3] = '{len: 30,  under_at: NONE, err_at: 4,    exp_valid: 13, exp_done: 0, exp_abort: 1};
      vecs[4] = '{len: 6,   under_at: NONE, err_at: 5,    exp_valid: 14, exp_done: 0, exp_abort: 1};
      vecs[5] = '{len: 64,  under_at: NONE, err_at: NONE, exp_valid: 76, exp_done: 1, exp_abort: 0};
      vecs[7] = '{len: 20,  under_at: 5,    err_at: 19,   exp_valid: 14, exp_done: 0, exp_abort: 1};

      fork
         begin : monitor
            int   cyc;
            int   last_cyc;
            bit   have_last;
            bit   prev_v;
            exp_t e;
            cyc = 0;
            last_cyc = 0;
            have_last = 1'b0;
            prev_v = 1'b0;
            forever begin
               @(negedge clk);
               cyc++;
               if (rst) begin
                  have_last = 1'b0;
                  prev_v    = 1'b0;
               end else begin
                  if (gmii.valid) begin
                     n_valid++;
                     if (!prev_v && have_last)
                        chk("ipg_gap_at_least_12", 32'((cyc - last_cyc - 1) >= IPG), 32'd1);
                     chk("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                     if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("gmii_data", 32'(gmii.data), 32'(e.data));
                        chk("gmii_error", 32'(gmii.error), 32'(e.err));
                        chk("tx_abort_pulse", 32'(tx_abort_o), 32'(e.err));
                        chk("tx_done_pulse", 32'(tx_done_o), 32'(e.done));
                     end
                     last_cyc  = cyc;
                     have_last = 1'b1;
                  end else begin
                     chk("idle_err_done_abort", 32'({gmii.error, tx_done_o, tx_abort_o}), 32'd0);
                  end
                  if (tx_done_o) n_done++;
                  if (tx_abort_o) n_abort++;
                  prev_v = gmii.valid;
               end
            end
         end
         begin : watchdog
            repeat (60000) @(posedge clk);
            $display("FAIL watchdog actual=still_running required=finished");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(gmii.valid), 32'd0);
      chk("rst_data", 32'(gmii.data), 32'd0);
      chk("rst_error", 32'(gmii.error), 32'd0);
      chk("rst_ready", 32'(s_ready_o), 32'd0);
      chk("rst_abort_done", 32'({tx_abort_o, tx_done_o}), 32'd0);
      #1 rst = 1'b0;

      // Frame table
      for (int v = 0; v < NVEC; v++) begin
         for (int k = 0; k < vecs[v].len; k++) pl[k] = 8'(k + v * 17);
         b_valid = n_valid;
         b_done  = n_done;
         b_abort = n_abort;
         push_frame(vecs[v].len, vecs[v].under_at, vecs[v].err_at);
         drive_frame(vecs[v].len, vecs[v].under_at, vecs[v].err_at, vecs[v].len);
         wait_done();
         chk($sformatf("vec%0d_valid_cycles", v), 32'(n_valid - b_valid), 32'(vecs[v].exp_valid));
         chk($sformatf("vec%0d_done_pulses", v), 32'(n_done - b_done), 32'(vecs[v].exp_done));
         chk($sformatf("vec%0d_abort_pulses", v), 32'(n_abort - b_abort), 32'(vecs[v].exp_abort));
      end

      // Known-answer CRC over "123456789"
      for (int k = 0; k < 9; k++) pl[k] = 8'(8'h31 + k);
`ifdef GMII_TX_PAD_EN
      push_frame(9, NONE, NONE);
`else
      push_hdr();
      for (int k = 0; k < 9; k++) push(pl[k], 1'b0, 1'b0);
      push(8'h26, 1'b0, 1'b0);
      push(8'h39, 1'b0, 1'b0);
      push(8'hF4, 1'b0, 1'b0);
      push(8'hCB, 1'b0, 1'b1);
`endif
      drive_frame(9, NONE, NONE, 9);
      wait_done();

      // Reset in the middle of the payload, after 15 bytes were accepted
      for (int k = 0; k < 40; k++) pl[k] = 8'(k) ^ 8'hA5;
      push_hdr();
      for (int k = 0; k < 15; k++) push(pl[k], 1'b0, 1'b0);
      drive_frame(40, NONE, NONE, 15);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", 32'(gmii.valid), 32'd0);
      chk("midrst_error", 32'(gmii.error), 32'd0);
      chk("midrst_ready", 32'(s_ready_o), 32'd0);
      chk("midrst_queue", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      #1 rst = 1'b0;

      // Clean frame after reset: CRC must start fresh
      for (int k = 0; k < 20; k++) pl[k] = 8'(8'hC0 + k * 3);
      b_valid = n_valid;
      b_done  = n_done;
      push_frame(20, NONE, NONE);
      drive_frame(20, NONE, NONE, 20);
      wait_done();
`ifdef GMII_TX_PAD_EN
      chk("post_rst_valid_cycles", 32'(n_valid - b_valid), 32'd72);
`else
      chk("post_rst_valid_cycles", 32'(n_valid - b_valid), 32'd32);
`endif
      chk("post_rst_done_pulses", 32'(n_done - b_done), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
